// File: rtl/fconv_pkg.sv
// ============================================================================
// Module  : fconv_pkg
// Brief   : Shared widths, state encoding and constants for the fConv front end
// Revision: 1.0
// ============================================================================
`default_nettype none

package fconv_pkg;

    localparam int FCONV_D_W = 12;

    // Most-negative 12-bit value; the converter treats it specially, the receiver does not
    localparam logic [FCONV_D_W-1:0] FCONV_SPECIAL = 12'h800;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } fconv_state_e;

endpackage

`default_nettype wire

// File: rtl/fconv_ser_shift.sv
// ============================================================================
// Module  : fconv_ser_shift
// Brief   : MSB-first shift register and bit counter with per-strobe event flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module fconv_ser_shift
    import fconv_pkg::*;
#(
    parameter int WIDTH = FCONV_D_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_frame,
    input  logic             i_data,
    input  logic             i_busy,
    output logic             o_start,
    output logic             o_shift,
    output logic             o_abort,
    output logic             o_done,
    output logic [WIDTH-1:0] o_word
);

    localparam int            CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 bits need storing: the final bit is taken straight from i_data
    logic [WIDTH-2:0] r_shift;
    logic [CW-1:0]    r_cnt;

    assign o_start = i_en & i_frame & ~i_busy;
    assign o_shift = i_en & i_frame & i_busy;
    assign o_abort = i_en & ~i_frame & i_busy;
    assign o_done  = o_shift & (r_cnt == C_LAST);
    assign o_word  = {r_shift, i_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (o_start) begin
            r_shift <= {{(WIDTH-2){1'b0}}, i_data};
            r_cnt   <= CW'(1);
        end else if (o_done || o_abort) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (o_shift) begin
            r_shift <= o_word[WIDTH-2:0];
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fconv_ser_rx.sv
// ============================================================================
// Module  : fconv_ser_rx
// Brief   : Framed serial receiver feeding fConv's D input via valid/ready,
//           with sticky framing/overrun flags and a saturating word counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module fconv_ser_rx
    import fconv_pkg::*;
#(
    parameter int WIDTH = FCONV_D_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ser_en,
    input  logic             i_ser_frame,
    input  logic             i_ser_data,
    input  logic             i_err_clr,
    input  logic             i_d_ready,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_d_valid,
    output logic             o_frm_err,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_wcount
);

    fconv_state_e     r_state;
    fconv_state_e     w_state_nxt;
    logic             w_busy;
    logic             w_start;
    logic             w_shift;
    logic             w_abort;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_load;
    logic             w_drop;

    logic [WIDTH-1:0] r_d_out;
    logic             r_d_valid;
    logic             r_frm_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_wcount;

    fconv_ser_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (i_ser_en),
        .i_frame (i_ser_frame),
        .i_data  (i_ser_data),
        .i_busy  (w_busy),
        .o_start (w_start),
        .o_shift (w_shift),
        .o_abort (w_abort),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = SHIFT;
            SHIFT:   if (w_done || w_abort) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == SHIFT);
    end

    // The holding register frees up on the same edge it is consumed
    assign w_load = w_done & (~r_d_valid | i_d_ready);
    assign w_drop = w_done & ~w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_out   <= '0;
            r_d_valid <= 1'b0;
            r_wcount  <= '0;
        end else if (w_load) begin
            r_d_out   <= w_word;
            r_d_valid <= 1'b1;
            if (r_wcount != {CNT_W{1'b1}}) begin
                r_wcount <= r_wcount + 1'b1;
            end
        end else if (r_d_valid && i_d_ready) begin
            r_d_valid <= 1'b0;
        end
    end

    // Set takes priority over clear so a coincident event is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_abort)        r_frm_err <= 1'b1;
            else if (i_err_clr) r_frm_err <= 1'b0;
            if (w_drop)         r_overrun <= 1'b1;
            else if (i_err_clr) r_overrun <= 1'b0;
        end
    end

    assign o_d_out   = r_d_out;
    assign o_d_valid = r_d_valid;
    assign o_frm_err = r_frm_err;
    assign o_overrun = r_overrun;
    assign o_wcount  = r_wcount;

endmodule

`default_nettype wire

// File: tb/tb_fconv_ser_rx.sv
// ============================================================================
// Module  : tb_fconv_ser_rx
// Brief   : Directed, table-driven self-checking bench for fconv_ser_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fconv_ser_rx;
    import fconv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ser_en;
    logic        ser_frame;
    logic        ser_data;
    logic        err_clr;
    logic        d_ready;
    logic [11:0] d_out;
    logic        d_valid;
    logic        frm_err;
    logic        overrun;
    logic [7:0]  wcount;

    int n_chk;
    int n_err;

    fconv_ser_rx #(
        .WIDTH (12),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ser_en    (ser_en),
        .i_ser_frame (ser_frame),
        .i_ser_data  (ser_data),
        .i_err_clr   (err_clr),
        .i_d_ready   (d_ready),
        .o_d_out     (d_out),
        .o_d_valid   (d_valid),
        .o_frm_err   (frm_err),
        .o_overrun   (overrun),
        .o_wcount    (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] word;
        logic        rdy_last;
        logic [11:0] exp_dout;
        logic        exp_valid;
        logic [7:0]  exp_wc;
        logic        exp_ovr;
        logic        rdy_after;
        logic        exp_valid_after;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ser_en    = 1'b0;
        ser_frame = 1'b0;
        ser_data  = 1'b0;
        err_clr   = 1'b0;
        d_ready   = 1'b0;
    endtask

    // Send nbits MSB-first bits of word; ready is only asserted on the final bit edge
    task automatic send_bits(input logic [11:0] word, input int nbits, input int gap,
                             input logic rdy_last);
        for (int i = 11; i > 11 - nbits; i--) begin
            repeat (gap) step();
            ser_en    = 1'b1;
            ser_frame = 1'b1;
            ser_data  = word[i];
            d_ready   = (i == 0) ? rdy_last : 1'b0;
            step();
            idle_inputs();
        end
    endtask

    task automatic drop_bit(input logic clr);
        ser_en    = 1'b1;
        ser_frame = 1'b0;
        ser_data  = 1'b1;
        err_clr   = clr;
        step();
        idle_inputs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},  {20'd0, d_out},  32'd0);
        chk({tag, "_valid"}, {31'd0, d_valid}, 32'd0);
        chk({tag, "_frm"},   {31'd0, frm_err}, 32'd0);
        chk({tag, "_ovr"},   {31'd0, overrun}, 32'd0);
        chk({tag, "_wc"},    {24'd0, wcount},  32'd0);
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk_all_zero(tag);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        idle_inputs();
        rst_n = 1'b1;
        step();
        do_reset("rst0");

        // Cumulative sequence: single word, hold + overrun, fill from empty, load-on-consume
        vecs[0] = '{12'h0A5,       1'b1, 12'h0A5,       1'b1, 8'd1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{FCONV_SPECIAL, 1'b0, FCONV_SPECIAL, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{12'h7FF,       1'b0, FCONV_SPECIAL, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{12'hFFF,       1'b0, 12'hFFF,       1'b1, 8'd3, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{12'h800,       1'b1, 12'h800,       1'b1, 8'd4, 1'b1, 1'b1, 1'b0};

        for (int v = 0; v < 5; v++) begin
            send_bits(vecs[v].word, 12, 0, vecs[v].rdy_last);
            chk($sformatf("v%0d_dout", v),  {20'd0, d_out},  {20'd0, vecs[v].exp_dout});
            chk($sformatf("v%0d_valid", v), {31'd0, d_valid}, {31'd0, vecs[v].exp_valid});
            chk($sformatf("v%0d_wc", v),    {24'd0, wcount},  {24'd0, vecs[v].exp_wc});
            chk($sformatf("v%0d_ovr", v),   {31'd0, overrun}, {31'd0, vecs[v].exp_ovr});
            chk($sformatf("v%0d_frm", v),   {31'd0, frm_err}, 32'd0);
            d_ready = vecs[v].rdy_after;
            step();
            d_ready = 1'b0;
            chk($sformatf("v%0d_valid_after", v), {31'd0, d_valid},
                {31'd0, vecs[v].exp_valid_after});
            chk($sformatf("v%0d_dout_after", v), {20'd0, d_out}, {20'd0, vecs[v].exp_dout});
        end

        // Frame dropped mid-word, recovery, and set-beats-clear on frm_err
        do_reset("rst1");
        send_bits(12'h123, 5, 0, 1'b0);
        drop_bit(1'b0);
        chk("ferr_set",   {31'd0, frm_err}, 32'd1);
        chk("ferr_noval", {31'd0, d_valid}, 32'd0);
        send_bits(12'h123, 12, 0, 1'b0);
        chk("ferr_rx_dout",  {20'd0, d_out},  32'h123);
        chk("ferr_rx_valid", {31'd0, d_valid}, 32'd1);
        chk("ferr_rx_wc",    {24'd0, wcount},  32'd1);
        chk("ferr_sticky",   {31'd0, frm_err}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ferr_clr", {31'd0, frm_err}, 32'd0);
        send_bits(12'h123, 3, 0, 1'b0);
        drop_bit(1'b1);
        chk("ferr_set_wins", {31'd0, frm_err}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ferr_clr2", {31'd0, frm_err}, 32'd0);

        // Asynchronous reset mid-word; partial word must not leak into the next frame
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        send_bits(12'h000, 6, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_all_zero("arst");
        step();
        rst_n = 1'b1;
        step();
        send_bits(12'hFFF, 12, 0, 1'b0);
        chk("arst_rx_dout",  {20'd0, d_out},  32'hFFF);
        chk("arst_rx_wc",    {24'd0, wcount},  32'd1);
        chk("arst_rx_valid", {31'd0, d_valid}, 32'd1);

        // Sparse strobes, then a word completing on the consume edge
        do_reset("rst2");
        send_bits(12'h456, 12, 2, 1'b0);
        chk("sparse_dout",  {20'd0, d_out},  32'h456);
        chk("sparse_valid", {31'd0, d_valid}, 32'd1);
        send_bits(12'h0A5, 12, 0, 1'b1);
        chk("swap_dout",  {20'd0, d_out},  32'h0A5);
        chk("swap_valid", {31'd0, d_valid}, 32'd1);
        chk("swap_ovr",   {31'd0, overrun}, 32'd0);
        chk("swap_wc",    {24'd0, wcount},  32'd2);

        // Counter saturation
        do_reset("rst3");
        for (int w = 1; w <= 257; w++) begin
            send_bits(w[11:0], 12, 0, 1'b1);
            if (w == 254) chk("sat_254", {24'd0, wcount}, 32'hFE);
            if (w == 255) chk("sat_255", {24'd0, wcount}, 32'hFF);
        end
        chk("sat_257",      {24'd0, wcount},  32'hFF);
        chk("sat_dout",     {20'd0, d_out},   32'h101);
        chk("sat_ovr",      {31'd0, overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
